wb_queue: RTL
=============

Name: wb_queue

Overview:
- Writeback-side driver of the register file's single write port (`we`/`wa`/`wd`).
- Merges ALU results (one per cycle, never stalled) and load results (valid/ready handshake) into an in-order write queue, then drains one write per cycle.
- Forwards pending values onto the decode-stage read path, so `rd1`/`rd2` always reflect the newest architectural value.

Parameters:
- DEPTH, 4, write-queue entries; legal range ≥2.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load result present.
- ld_ready  out  1  load result accepted this cycle when high with ld_valid.
- ld_rd  in  5  load destination register.
- ld_data  in  XLEN  load result.
- rf_we  out  1  register file write enable.
- rf_wa  out  5  register file write address.
- rf_wd  out  XLEN  register file write data.
- ra1  in  5  decode read address 1; also driven to the register file.
- ra2  in  5  decode read address 2; also driven to the register file.
- rf_rd1  in  XLEN  register file read data 1 (combinational read).
- rf_rd2  in  XLEN  register file read data 2.
- rd1  out  XLEN  forwarded read data 1.
- rd2  out  XLEN  forwarded read data 2.

Behaviour:
- State:
  - queue Q of DEPTH entries (rd, data) with occupancy `count`.
  - output register (`rf_we`, `rf_wa`, `rf_wd`).
- Reset: Q emptied, `count`=0, `rf_we`=0, `rf_wa`=0, `rf_wd`=0.
  - Reset mid-operation discards all pending writes; none reach the register file after the reset edge.
- Each posedge with rst=0, in this order:
  - Pop: if `count`>0, head moves to the output register with `rf_we`=1; otherwise `rf_we`=0 and `rf_wa`/`rf_wd` hold their values.
  - Push load: if `ld_valid` && `ld_ready`, push (`ld_rd`, `ld_data`).
  - Push ALU: then, if `alu_valid`, push (`alu_rd`, `alu_data`).
  - Same-cycle ordering: a load is older than a same-cycle ALU result, so it is pushed first.
- x0 filter: any accepted result with rd==0 is consumed but not pushed, so `rf_we` never asserts with `rf_wa`==0.
- `ld_ready` = (`count` < DEPTH), combinational from registered `count`.
  - Guarantees ≤DEPTH entries after pop plus two pushes.
  - An ALU push always fits; `alu_valid` is never back-pressured.
- Latency:
  - Result accepted at edge N with Q empty drives `rf_we`=1 during the cycle after edge N+1.
  - The register file holds it after edge N+2.
  - Each older queued entry adds one cycle.
- Write order to the register file equals acceptance order.
- Forwarding (combinational), per read port p:
  - p's address==0 → 0.
  - Else, if it matches any valid Q entry → data of the youngest matching entry.
  - Else, if `rf_we` && `rf_wa`==address → `rf_wd`.
  - Else → `rf_rd<p>`.
- Forwarding does not see results arriving in the current cycle; only accepted (queued) state.
- Queue pointers wrap modulo DEPTH. `count` must never exceed DEPTH; overflow is a design error and is asserted in the bench.

Test Plan:
- Reset: assert rst 2 cycles with `alu_valid`=1 → `rf_we`=0, `ld_ready`=1, `count`=0; `rd1` equals `rf_rd1` for `ra1`=7.
- Single ALU write:
  - Stimulus: `alu_rd`=3, `alu_data`=12 for one cycle, `ra1`=3.
  - Required: `rd1`=12 from the cycle after acceptance onward.
  - Required: `rf_we`=1, `rf_wa`=3, `rf_wd`=12 for exactly one cycle, one cycle later.
- x0 discard: ALU `rd`=0, `data`=100 → `rf_we` stays 0 for 4 cycles; `rd1`=0 with `ra1`=0.
- Same-cycle collision:
  - Stimulus: load (`rd`=5, 0xAA) and ALU (`rd`=5, 0xBB) in the same cycle, `ra2`=5.
  - Required: writes 5←0xAA then 5←0xBB on consecutive cycles.
  - Required: `rd2`=0xBB from the cycle after acceptance onward.
- Backpressure (DEPTH=2):
  - Stimulus: load and ALU valid every cycle, distinct rd 1..20.
  - Required: `ld_ready` deasserts when `count`==2 and the load holds its data while stalled.
  - Required: all 20 writes appear in acceptance order with none lost or duplicated, and `count` ≤2 throughout.
- Reset mid-flight:
  - Stimulus: fill Q with 3 entries, assert rst one cycle.
  - Required: `rf_we`=0 from the next cycle and no queued entry is ever written.
  - Required: `rd1` for a queued register returns `rf_rd1`.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback queue merging ALU and load results onto one register-file write port, with read forwarding
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % DEPTH);
    endfunction

    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail, alu_idx, fidx;
    logic [CW-1:0]   count_q, count_d;
    logic            rf_we_q;
    logic [4:0]      rf_wa_q;
    logic [XLEN-1:0] rf_wd_q;
    logic            pop, ld_push, alu_push;

    assign rf_we = rf_we_q;
    assign rf_wa = rf_wa_q;
    assign rf_wd = rf_wd_q;

    // Pop the head every cycle it exists; a load is older than a same-cycle ALU result, so it takes the first free slot
    always_comb begin
        pop      = count_q != '0;
        ld_ready = count_q < CW'(DEPTH);
        ld_push  = ld_valid && ld_ready && ld_rd != 5'd0;
        alu_push = alu_valid && alu_rd != 5'd0;
        tail     = wrap(int'(head_q) + int'(count_q));
        alu_idx  = wrap(int'(tail) + int'(ld_push));
        head_d   = pop ? wrap(int'(head_q) + 1) : head_q;
        count_d  = count_q - CW'(pop) + CW'(ld_push) + CW'(alu_push);
    end

    // Queue bookkeeping and the register-file write port; a reset discards everything pending
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            count_q <= '0;
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
            rf_we_q <= pop;
            if (pop) begin
                rf_wa_q <= rd_q[head_q];
                rf_wd_q <= data_q[head_q];
            end
        end
    end

    // Entry storage; slots are only meaningful below count, so no reset is needed
    always_ff @(posedge clk) begin
        if (ld_push) begin
            rd_q[tail]   <= ld_rd;
            data_q[tail] <= ld_data;
        end
        if (alu_push) begin
            rd_q[alu_idx]   <= alu_rd;
            data_q[alu_idx] <= alu_data;
        end
    end

    // Forwarding priority: x0, youngest queued entry, output register, then the register file itself
    always_comb begin
        rd1  = (rf_we_q && rf_wa_q == ra1) ? rf_wd_q : rf_rd1;
        rd2  = (rf_we_q && rf_wa_q == ra2) ? rf_wd_q : rf_rd2;
        fidx = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            fidx = wrap(int'(head_q) + k);
            if (k < int'(count_q) && rd_q[fidx] == ra1) rd1 = data_q[fidx];
            if (k < int'(count_q) && rd_q[fidx] == ra2) rd2 = data_q[fidx];
        end
        rd1 = ra1 == 5'd0 ? '0 : rd1;
        rd2 = ra2 == 5'd0 ? '0 : rd2;
    end
endmodule
